// File: rtl/head_sram_pkg.sv
// Shared types and constants for the head-buffer SRAM arbiter.
package head_sram_pkg;

    typedef enum logic [1:0] {
        WM_ROW     = 2'd0,
        WM_SLICE   = 2'd1,
        WM_GROUP   = 2'd2,
        WM_ILLEGAL = 2'd3
    } wmode_e;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } hold_state_e;

    // Slices covered by one group-mode write.
    localparam int GROUP_SLICES = 4;

endpackage

// File: rtl/head_sram_if_hold.sv
// Interface holding register: captures one host request, counts how long it has
// waited behind the core and decides when it may use the memory ports.
module head_sram_if_hold
    import head_sram_pkg::*;
#(
    parameter int ROW_W    = 5,
    parameter int WORD_W   = 3,
    parameter int IF_WIDTH = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    i_req,
    input  logic                    i_we,
    input  logic [ROW_W+WORD_W-1:0] i_addr,
    input  logic [IF_WIDTH-1:0]     i_wdata,
    input  logic                    i_core_rd_acc,
    input  logic                    i_core_wr_load,
    output hold_state_e             o_state,
    output logic                    o_core_ready,
    output logic                    o_drain_rd,
    output logic                    o_drain_wr,
    output logic [ROW_W-1:0]        o_row,
    output logic [WORD_W-1:0]       o_word,
    output logic [IF_WIDTH-1:0]     o_wdata
);

    localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    hold_state_e         r_state;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic                r_core_ready;
    logic                r_we;
    logic [ROW_W-1:0]    r_row;
    logic [WORD_W-1:0]   r_word;
    logic [IF_WIDTH-1:0] r_wdata;

    logic                w_drain_rd;
    logic                w_drain_wr;
    logic                w_drain;
    logic [WAIT_W-1:0]   w_wait_nxt;

    // A pending read needs the read port, a pending write needs the write stage;
    // the core has first claim on both.
    assign w_drain_rd = (r_state == PEND) && !r_we && !i_core_rd_acc;
    assign w_drain_wr = (r_state == PEND) &&  r_we && !i_core_wr_load;
    assign w_drain    = w_drain_rd || w_drain_wr;
    assign w_wait_nxt = (r_wait_cnt == WAIT_MAX) ? r_wait_cnt : r_wait_cnt + 1'b1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= IDLE;
            r_wait_cnt   <= '0;
            r_core_ready <= 1'b1;
            r_we         <= 1'b0;
            r_row        <= '0;
            r_word       <= '0;
            r_wdata      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_req) begin
                        r_state      <= PEND;
                        r_we         <= i_we;
                        r_row        <= i_addr[ROW_W+WORD_W-1 -: ROW_W];
                        r_word       <= i_addr[WORD_W-1:0];
                        r_wdata      <= i_wdata;
                        r_wait_cnt   <= '0;
                        r_core_ready <= (WAIT_MAX != '0);
                    end
                end
                PEND: begin
                    if (w_drain) begin
                        r_state      <= IDLE;
                        r_wait_cnt   <= '0;
                        r_core_ready <= 1'b1;
                    end else begin
                        // Stall the core for the cycle in which the count hits the limit.
                        r_wait_cnt   <= w_wait_nxt;
                        r_core_ready <= (w_wait_nxt != WAIT_MAX);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_state      = r_state;
    assign o_core_ready = r_core_ready;
    assign o_drain_rd   = w_drain_rd;
    assign o_drain_wr   = w_drain_wr;
    assign o_row        = r_row;
    assign o_word       = r_word;
    assign o_wdata      = r_wdata;

endmodule

// File: rtl/mem_dp.sv
// Behavioural model of the dual-port SRAM macro: one read port, one write port,
// registered read data, read-first on a same-row collision, optional byte enables.
module mem_dp #(
    parameter int DATA_WIDTH = 128,
    parameter int DEPTH      = 32,
    parameter int BWE        = 1,
    parameter int ROW_W      = $clog2(DEPTH),
    parameter int BE_W       = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  i_ren,
    input  logic [ROW_W-1:0]      i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata,
    input  logic                  i_wen,
    input  logic [ROW_W-1:0]      i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [BE_W-1:0]       i_wbe
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_wen) begin
            for (int b = 0; b < BE_W; b++) begin
                if (BWE == 0 || i_wbe[b]) begin
                    r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
        if (i_ren) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/head_sram_arb.sv
// Head-buffer SRAM arbiter: core datapath and host interface share one mem_dp
// macro through a single write stage, with read-after-write forwarding.
module head_sram_arb
    import head_sram_pkg::*;
#(
    parameter int DATA_WIDTH    = 128,
    parameter int SLICE_BIT     = 8,
    parameter int DEPTH         = 32,
    parameter int IF_WIDTH      = 16,
    parameter int MAX_WAIT      = 4,
    parameter int ADDR_WIDTH    = $clog2(DATA_WIDTH / SLICE_BIT) + $clog2(DEPTH),
    parameter int IF_ADDR_WIDTH = $clog2(DEPTH) + $clog2(DATA_WIDTH / IF_WIDTH)
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     core_ren,
    input  logic [ADDR_WIDTH-1:0]    core_raddr,
    output logic [DATA_WIDTH-1:0]    core_rdata,
    output logic                     core_rvalid,
    input  logic                     core_wen,
    input  logic [ADDR_WIDTH-1:0]    core_waddr,
    input  logic [DATA_WIDTH-1:0]    core_wdata,
    input  logic [1:0]               core_wmode,
    output logic                     core_ready,
    output logic                     err_mode,
    input  logic                     if_req,
    input  logic                     if_we,
    input  logic [IF_ADDR_WIDTH-1:0] if_addr,
    input  logic [IF_WIDTH-1:0]      if_wdata,
    output logic                     if_ready,
    output logic [IF_WIDTH-1:0]      if_rdata,
    output logic                     if_rvalid
);

    localparam int SLICE_NUM   = DATA_WIDTH / SLICE_BIT;
    localparam int SEL_W       = $clog2(SLICE_NUM);
    localparam int ROW_W       = $clog2(DEPTH);
    localparam int IF_WORDS    = DATA_WIDTH / IF_WIDTH;
    localparam int WORD_W      = $clog2(IF_WORDS);
    localparam int BE_W        = DATA_WIDTH / 8;
    localparam int SLICE_BYTES = SLICE_BIT / 8;
    localparam int IF_BYTES    = IF_WIDTH / 8;

    localparam logic [BE_W-1:0]  SLICE_BE = BE_W'({SLICE_BYTES{1'b1}});
    localparam logic [BE_W-1:0]  GROUP_BE = BE_W'({(GROUP_SLICES*SLICE_BYTES){1'b1}});
    localparam logic [BE_W-1:0]  IF_BE    = BE_W'({IF_BYTES{1'b1}});
    localparam logic [SEL_W-1:0] GRP_MASK = SEL_W'(GROUP_SLICES - 1);

    // Core write decode
    wmode_e                w_wmode;
    logic [SEL_W-1:0]      w_sel;
    logic [ROW_W-1:0]      w_wrow;
    logic                  w_wr_ok;
    logic [DATA_WIDTH-1:0] w_cw_data;
    logic [BE_W-1:0]       w_cw_be;
    logic                  w_core_rd_acc;
    logic                  w_core_wr_acc;
    logic                  w_core_wr_load;
    logic                  w_unused;

    // Holding register interface
    hold_state_e           w_hold_state;
    logic                  w_core_ready;
    logic                  w_drain_rd;
    logic                  w_drain_wr;
    logic [ROW_W-1:0]      w_hold_row;
    logic [WORD_W-1:0]     w_hold_word;
    logic [IF_WIDTH-1:0]   w_hold_wdata;
    logic [DATA_WIDTH-1:0] w_if_data;
    logic [BE_W-1:0]       w_if_be;

    // Memory ports
    logic                  w_mem_ren;
    logic [ROW_W-1:0]      w_mem_raddr;
    logic [DATA_WIDTH-1:0] w_mem_rdata;
    logic [DATA_WIDTH-1:0] w_rd_merged;

    // Write stage and read pipeline
    logic                  r_st_valid;
    logic [ROW_W-1:0]      r_st_row;
    logic [DATA_WIDTH-1:0] r_st_data;
    logic [BE_W-1:0]       r_st_be;
    logic                  r_rd_core;
    logic                  r_rd_if;
    logic [WORD_W-1:0]     r_rd_word;
    logic                  r_fwd_hit;
    logic [DATA_WIDTH-1:0] r_fwd_data;
    logic [BE_W-1:0]       r_fwd_be;
    logic [DATA_WIDTH-1:0] r_core_rdata;
    logic                  r_core_rvalid;
    logic [IF_WIDTH-1:0]   r_if_rdata;
    logic                  r_if_rvalid;
    logic                  r_err_mode;

    assign w_wmode        = wmode_e'(core_wmode);
    assign w_sel          = core_waddr[ADDR_WIDTH-1 -: SEL_W];
    assign w_wrow         = core_waddr[ROW_W-1:0];
    assign w_core_rd_acc  = core_ren && w_core_ready;
    assign w_core_wr_acc  = core_wen && w_core_ready;
    assign w_core_wr_load = w_core_wr_acc && w_wr_ok;
    assign w_unused       = ^core_raddr[ADDR_WIDTH-1:ROW_W];

    always_comb begin
        w_wr_ok   = 1'b0;
        w_cw_data = '0;
        w_cw_be   = '0;
        case (w_wmode)
            WM_ROW: begin
                w_wr_ok   = 1'b1;
                w_cw_data = core_wdata;
                w_cw_be   = '1;
            end
            WM_SLICE: begin
                w_wr_ok   = 1'b1;
                w_cw_data = DATA_WIDTH'(core_wdata[SLICE_BIT-1:0]) << (w_sel * SLICE_BIT);
                w_cw_be   = SLICE_BE << (w_sel * SLICE_BYTES);
            end
            WM_GROUP: begin
                w_wr_ok   = ((w_sel & GRP_MASK) == '0);
                w_cw_data = DATA_WIDTH'(core_wdata[GROUP_SLICES*SLICE_BIT-1:0]) << (w_sel * SLICE_BIT);
                w_cw_be   = GROUP_BE << (w_sel * SLICE_BYTES);
            end
            default: w_wr_ok = 1'b0;
        endcase
    end

    head_sram_if_hold #(
        .ROW_W    (ROW_W),
        .WORD_W   (WORD_W),
        .IF_WIDTH (IF_WIDTH),
        .MAX_WAIT (MAX_WAIT)
    ) u_if_hold (
        .clk            (clk),
        .rstn           (rstn),
        .i_req          (if_req),
        .i_we           (if_we),
        .i_addr         (if_addr),
        .i_wdata        (if_wdata),
        .i_core_rd_acc  (w_core_rd_acc),
        .i_core_wr_load (w_core_wr_load),
        .o_state        (w_hold_state),
        .o_core_ready   (w_core_ready),
        .o_drain_rd     (w_drain_rd),
        .o_drain_wr     (w_drain_wr),
        .o_row          (w_hold_row),
        .o_word         (w_hold_word),
        .o_wdata        (w_hold_wdata)
    );

    assign w_if_data   = DATA_WIDTH'(w_hold_wdata) << (w_hold_word * IF_WIDTH);
    assign w_if_be     = IF_BE << (w_hold_word * IF_BYTES);
    assign w_mem_ren   = w_core_rd_acc || w_drain_rd;
    assign w_mem_raddr = w_core_rd_acc ? core_raddr[ROW_W-1:0] : w_hold_row;

    mem_dp #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .BWE        (1)
    ) u_mem (
        .clk     (clk),
        .i_ren   (w_mem_ren),
        .i_raddr (w_mem_raddr),
        .o_rdata (w_mem_rdata),
        .i_wen   (r_st_valid),
        .i_waddr (r_st_row),
        .i_wdata (r_st_data),
        .i_wbe   (r_st_be)
    );

    // The macro reads old data on a collision, so stage bytes are patched in afterwards.
    always_comb begin
        w_rd_merged = w_mem_rdata;
        for (int b = 0; b < BE_W; b++) begin
            if (r_fwd_hit && r_fwd_be[b]) begin
                w_rd_merged[b*8 +: 8] = r_fwd_data[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_st_valid    <= 1'b0;
            r_st_row      <= '0;
            r_st_data     <= '0;
            r_st_be       <= '0;
            r_rd_core     <= 1'b0;
            r_rd_if       <= 1'b0;
            r_rd_word     <= '0;
            r_fwd_hit     <= 1'b0;
            r_fwd_data    <= '0;
            r_fwd_be      <= '0;
            r_core_rdata  <= '0;
            r_core_rvalid <= 1'b0;
            r_if_rdata    <= '0;
            r_if_rvalid   <= 1'b0;
            r_err_mode    <= 1'b0;
        end else begin
            if (w_core_wr_load) begin
                r_st_valid <= 1'b1;
                r_st_row   <= w_wrow;
                r_st_data  <= w_cw_data;
                r_st_be    <= w_cw_be;
            end else if (w_drain_wr) begin
                r_st_valid <= 1'b1;
                r_st_row   <= w_hold_row;
                r_st_data  <= w_if_data;
                r_st_be    <= w_if_be;
            end else begin
                r_st_valid <= 1'b0;
            end

            r_rd_core  <= w_core_rd_acc;
            r_rd_if    <= w_drain_rd;
            r_rd_word  <= w_hold_word;
            r_fwd_hit  <= w_mem_ren && r_st_valid && (r_st_row == w_mem_raddr);
            r_fwd_data <= r_st_data;
            r_fwd_be   <= r_st_be;

            r_core_rvalid <= r_rd_core;
            if (r_rd_core) begin
                r_core_rdata <= w_rd_merged;
            end
            r_if_rvalid <= r_rd_if;
            if (r_rd_if) begin
                r_if_rdata <= w_rd_merged[r_rd_word*IF_WIDTH +: IF_WIDTH];
            end

            r_err_mode <= w_core_wr_acc && !w_wr_ok;
        end
    end

    assign core_rdata  = r_core_rdata;
    assign core_rvalid = r_core_rvalid;
    assign core_ready  = w_core_ready;
    assign err_mode    = r_err_mode;
    assign if_ready    = (w_hold_state == IDLE);
    assign if_rdata    = r_if_rdata;
    assign if_rvalid   = r_if_rvalid;

endmodule
